// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore sequencer for a shared-memory, single-ALU datapath.
// Handles memory wait states, traps illegal opcodes and counts retired instructions.
module mips_multicycle_ctrl #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 memready,
  output logic                 iord,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 regwrite,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic [1:0]           pcsrc,
  output logic [2:0]           alucontrol,
  output logic                 pcen,
  output logic                 illegal,
  output logic [3:0]           state,
  output logic [CNT_WIDTH-1:0] instret
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;
  localparam logic [3:0] S_ERROR   = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  logic [3:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] instret_q;
  logic [1:0]           aluop;
  logic                 retire;
  logic                 funct_ok;
  logic                 pcen_raw, irwrite_raw, memwrite_raw, regwrite_raw;

  always_comb begin
    funct_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
               (funct == FN_OR)  || (funct == FN_SLT);
  end

  always_comb begin
    state_d      = state_q;
    iord         = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    regwrite_raw = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    aluop        = 2'b00;
    pcen_raw     = 1'b0;
    retire       = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb     = 2'b01;
        irwrite_raw = memready;
        pcen_raw    = memready;
        if (memready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = funct_ok ? S_EXECUTE : S_ERROR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ERROR;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (memready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
        if (memready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        aluop    = 2'b01;
        pcsrc    = 2'b01;
        pcen_raw = zero;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_raw = 1'b1;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      S_JUMP: begin
        pcsrc    = 2'b10;
        pcen_raw = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
  end

  always_comb begin
    case (aluop)
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          FN_SUB:  alucontrol = 3'b110;
          FN_AND:  alucontrol = 3'b000;
          FN_OR:   alucontrol = 3'b001;
          FN_SLT:  alucontrol = 3'b111;
          default: alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

  // Write enables are masked by reset so an abandoned access drops immediately, not at the next edge.
  always_comb begin
    pcen     = pcen_raw & reset;
    irwrite  = irwrite_raw & reset;
    memwrite = memwrite_raw & reset;
    regwrite = regwrite_raw & reset;
    illegal  = (state_q == S_ERROR);
    state    = state_q;
    instret  = instret_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized self-checking bench: a per-instruction step model predicts every cycle's outputs.
// A second instance with a 4-bit counter checks instret wrap-around.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       memready = 1'b0;

  logic iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  logic [31:0] instret;

  logic iord4, memwrite4, irwrite4, regdst4, memtoreg4, regwrite4, alusrca4, pcen4, illegal4;
  logic [1:0] alusrcb4, pcsrc4;
  logic [2:0] alucontrol4;
  logic [3:0] state4;
  logic [3:0] instret4;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .alucontrol(alucontrol), .pcen(pcen), .illegal(illegal),
    .state(state), .instret(instret)
  );

  mips_multicycle_ctrl #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
    .iord(iord4), .memwrite(memwrite4), .irwrite(irwrite4), .regdst(regdst4),
    .memtoreg(memtoreg4), .regwrite(regwrite4), .alusrca(alusrca4), .alusrcb(alusrcb4),
    .pcsrc(pcsrc4), .alucontrol(alucontrol4), .pcen(pcen4), .illegal(illegal4),
    .state(state4), .instret(instret4)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] aluc;
    logic pcen, illegal;
  } obs_t;

  typedef struct {
    obs_t exp;
    logic mr;
    bit   retire;
  } step_t;

  obs_t act, act4;
  assign act  = {state, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                 alusrcb, pcsrc, alucontrol, pcen, illegal};
  assign act4 = {state4, iord4, memwrite4, irwrite4, regdst4, memtoreg4, regwrite4, alusrca4,
                 alusrcb4, pcsrc4, alucontrol4, pcen4, illegal4};

  step_t q[$];
  int checks = 0;
  int failures = 0;
  longint unsigned cnt = 0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  // Instruction class from the opcode/funct rules: 0 lw,1 sw,2 R,3 beq,4 addi,5 j,6 illegal.
  function automatic int kind_of(input logic [5:0] o, input logic [5:0] f);
    case (o)
      LW:   return 0;
      SW:   return 1;
      RT:   return (f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
                    f == 6'b100101 || f == 6'b101010) ? 2 : 6;
      BEQ:  return 3;
      ADDI: return 4;
      JMP:  return 5;
      default: return 6;
    endcase
  endfunction

  function automatic logic [2:0] rfn(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic obs_t base(input logic [3:0] st);
    obs_t o;
    o = '0;
    o.st = st;
    o.aluc = 3'b010;
    return o;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input obs_t e, input logic mr, input bit r);
    step_t s;
    s.exp = e; s.mr = mr; s.retire = r;
    q.push_back(s);
  endtask

  task automatic queue_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int wf, input int wm);
    obs_t e;
    int k;
    k = kind_of(o, f);
    for (int i = 0; i < wf; i++) begin
      e = base(4'd0); e.alusrcb = 2'b01; push(e, 1'b0, 0);
    end
    e = base(4'd0); e.alusrcb = 2'b01; e.irwrite = 1; e.pcen = 1; push(e, 1'b1, 0);
    e = base(4'd1); e.alusrcb = 2'b11; push(e, rnd(), 0);
    case (k)
      0, 1: begin
        e = base(4'd2); e.alusrca = 1; e.alusrcb = 2'b10; push(e, rnd(), 0);
        if (k == 0) begin
          for (int i = 0; i < wm; i++) begin
            e = base(4'd3); e.iord = 1; push(e, 1'b0, 0);
          end
          e = base(4'd3); e.iord = 1; push(e, 1'b1, 0);
          e = base(4'd4); e.memtoreg = 1; e.regwrite = 1; push(e, rnd(), 1);
        end else begin
          for (int i = 0; i < wm; i++) begin
            e = base(4'd5); e.iord = 1; e.memwrite = 1; push(e, 1'b0, 0);
          end
          e = base(4'd5); e.iord = 1; e.memwrite = 1; push(e, 1'b1, 1);
        end
      end
      2: begin
        e = base(4'd6); e.alusrca = 1; e.aluc = rfn(f); push(e, rnd(), 0);
        e = base(4'd7); e.regdst = 1; e.regwrite = 1; push(e, rnd(), 1);
      end
      3: begin
        e = base(4'd8); e.alusrca = 1; e.aluc = 3'b110; e.pcsrc = 2'b01; e.pcen = z;
        push(e, rnd(), 1);
      end
      4: begin
        e = base(4'd9); e.alusrca = 1; e.alusrcb = 2'b10; push(e, rnd(), 0);
        e = base(4'd10); e.regwrite = 1; push(e, rnd(), 1);
      end
      5: begin
        e = base(4'd11); e.pcsrc = 2'b10; e.pcen = 1; push(e, rnd(), 1);
      end
      default: begin
        for (int i = 0; i < 20; i++) begin
          e = base(4'd15); e.illegal = 1; push(e, rnd(), 0);
        end
      end
    endcase
  endtask

  // Called at posedge+1; each step drives memready, checks at negedge, then advances one edge.
  task automatic run_steps(input string tag, input int n);
    step_t s;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      s = q.pop_front();
      memready = s.mr;
      @(negedge clk);
      checks++;
      if (act !== s.exp)
        $display("FAIL %s step%0d outputs: got %h want %h", tag, i, act, s.exp);
      if (act !== s.exp) failures++;
      checks++;
      if (act4 !== s.exp) begin
        failures++;
        $display("FAIL %s step%0d outputs(w4): got %h want %h", tag, i, act4, s.exp);
      end
      checks++;
      if (instret !== cnt[31:0] || instret4 !== cnt[3:0]) begin
        failures++;
        $display("FAIL %s step%0d instret: got %0d/%0d want %0d/%0d", tag, i,
                 instret, instret4, cnt[31:0], cnt[3:0]);
      end
      @(posedge clk);
      #1;
      if (s.retire) cnt++;
    end
  endtask

  task automatic exec(input string tag, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input int wf, input int wm);
    op = o; funct = f; zero = z;
    queue_instr(o, f, z, wf, wm);
    run_steps(tag, 1000);
  endtask

  task automatic check_count(input string tag);
    checks++;
    if (instret !== cnt[31:0] || instret4 !== cnt[3:0]) begin
      failures++;
      $display("FAIL %s count: got %0d/%0d want %0d/%0d", tag, instret, instret4,
               cnt[31:0], cnt[3:0]);
    end
  endtask

  // Called at posedge+1; asserts reset between edges with memready high to expose gating.
  task automatic do_reset(input string tag);
    obs_t e;
    reset = 1'b0;
    memready = 1'b1;
    #2;
    cnt = 0;
    q.delete();
    e = base(4'd0); e.alusrcb = 2'b01;
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s reset outputs: got %h want %h", tag, act, e);
    end
    check_count(tag);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    do_reset("reset");
  endtask

  task automatic test_rtype();
    exec("add", RT, 6'b100000, 1'b0, 0, 0);
    check_count("add_retire");
  endtask

  task automatic test_lw_wait();
    exec("lw_wait", LW, 6'($urandom), 1'b0, 0, 2);
    exec("lw_fwait", LW, 6'($urandom), 1'b1, 3, 1);
    check_count("lw_retire");
  endtask

  task automatic test_beq();
    exec("beq_taken", BEQ, 6'($urandom), 1'b1, 0, 0);
    exec("beq_not", BEQ, 6'($urandom), 1'b0, 0, 0);
    check_count("beq_retire");
  endtask

  task automatic test_illegal();
    exec("bad_op", 6'b111111, 6'($urandom), 1'b0, 0, 0);
    do_reset("bad_op_clr");
    exec("bad_funct", RT, 6'b000000, 1'b0, 1, 0);
    do_reset("bad_funct_clr");
    exec("post_err", ADDI, 6'($urandom), 1'b0, 0, 0);
  endtask

  task automatic test_reset_mid_sw();
    op = SW; funct = '0; zero = 1'b0;
    queue_instr(SW, 6'b0, 1'b0, 0, 5);
    run_steps("sw_pre", 4);
    memready = 1'b0;
    #2;
    checks++;
    if (memwrite !== 1'b1 || state !== 4'd5) begin
      failures++;
      $display("FAIL sw_hold: got memwrite=%b state=%0d want 1/5", memwrite, state);
    end
    reset = 1'b0;
    #1;
    cnt = 0;
    q.delete();
    checks++;
    if (memwrite !== 1'b0 || state !== 4'd0 || iord !== 1'b0) begin
      failures++;
      $display("FAIL sw_abort: got memwrite=%b state=%0d iord=%b want 0/0/0",
               memwrite, state, iord);
    end
    check_count("sw_abort");
    @(posedge clk);
    #1;
    reset = 1'b1;
    exec("after_abort", JMP, 6'($urandom), 1'b0, 1, 0);
  endtask

  task automatic test_jump_wrap();
    @(posedge clk);
    #1;
    do_reset("wrap_rst");
    for (int i = 0; i < 17; i++) exec("j_wrap", JMP, 6'($urandom), rnd(), 0, 0);
    check_count("j_wrap_final");
    checks++;
    if (instret4 !== 4'd1) begin
      failures++;
      $display("FAIL j_wrap4: got %0d want 1", instret4);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops[6];
    logic [5:0] fns[5];
    logic [5:0] o, f;
    ops = '{LW, SW, RT, BEQ, ADDI, JMP};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    for (int i = 0; i < 150; i++) begin
      o = ops[$urandom_range(0, 5)];
      f = (o == RT) ? fns[$urandom_range(0, 4)] : 6'($urandom);
      exec("random", o, f, rnd(), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end
    check_count("random_final");
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq();
    test_illegal();
    test_reset_mid_sw();
    test_random();
    test_jump_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multicycle sequencer for the MIPS datapath. One shared memory port serves instruction fetch and data access, and one ALU serves PC increment, branch target, address and result computation. Decodes op/funct, steps a Moore FSM through fetch/decode/execute/writeback, and drives all datapath mux selects and write enables. Supports memory wait states via memready, traps illegal instructions, and counts retired instructions.

Parameters:
CNT_WIDTH, 32, width of retired-instruction counter instret

Ports:
clk  input  1  single clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset; state/counter cleared immediately on assertion (low)
op  input  6  instr[31:26] from instruction register
funct  input  6  instr[5:0] from instruction register
zero  input  1  ALU zero flag
memready  input  1  memory completes current access this cycle
iord  output  1  memory address select: 0=PC, 1=ALUOut
memwrite  output  1  memory write enable
irwrite  output  1  instruction register load enable
regdst  output  1  write-register select: 0=rt, 1=rd
memtoreg  output  1  writeback select: 0=ALUOut, 1=memory data
regwrite  output  1  register file write enable
alusrca  output  1  ALU A: 0=PC, 1=rs
alusrcb  output  2  ALU B: 00=rt, 01=const 4, 10=signimm, 11=signimm<<2
pcsrc  output  2  next PC: 00=ALU result, 01=ALUOut, 10=jump target
alucontrol  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
pcen  output  1  PC register enable
illegal  output  1  sticky illegal-instruction flag
state  output  4  current FSM state encoding (debug)
instret  output  CNT_WIDTH  retired-instruction count

Behaviour:
- Moore FSM; outputs decode combinationally from state, plus zero/memready where noted. Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, ERROR=15.
- Default for all outputs not listed per state: 0. Internal aluop defaults to 00.
- Reset low: state=FETCH, instret=0, illegal=0. pcen, irwrite, memwrite and regwrite are forced 0 while reset is low. Reset mid-operation abandons the instruction, with no partial write after release.
- FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00. If memready=1, then irwrite=1, pcen=1 and next state is DECODE; otherwise stay in FETCH with irwrite=pcen=0.
- DECODE: alusrca=0, alusrcb=11, aluop=00. Next state by op:
  - 100011/101011 -> MEMADR
  - 000000 -> EXECUTE if funct is in {100000, 100010, 100100, 100101, 101010}, else ERROR
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - any other op -> ERROR
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Hold until memready=1, then go to MEMWB.
- MEMWB: memtoreg=1, regdst=0, regwrite=1. Next is FETCH.
- MEMWR: iord=1, memwrite=1 every cycle in state. Hold until memready=1, then go to FETCH.
- EXECUTE: alusrca=1, alusrcb=00, aluop=10. Next is ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1. Next is FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, pcen=zero. Next is FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Next is ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next is FETCH.
- JUMP: pcsrc=10, pcen=1. Next is FETCH.
- ERROR: all enables 0, illegal=1. Absorbing until reset; memready is ignored.
- alucontrol mapping:
  - aluop 00 -> 010
  - aluop 01 -> 110
  - aluop 10 -> by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111
- instret increments by 1 on each clock edge leaving MEMWB, ALUWB, BRANCH (taken or not), ADDIWB, JUMP, or MEMWR with memready=1. It wraps modulo 2^CNT_WIDTH with no saturation.
- Cycle counts with memready held 1: lw 5; sw, R-type and addi 4; beq and j 3.
- Each additional cycle memready is low in FETCH/MEMRD/MEMWR adds exactly one cycle. Outputs are held stable during the wait.

Test Plan:
- Release reset, memready=1, op=000000, funct=100000 -> state sequence 0,1,6,7,0. irwrite=pcen=1 in FETCH; alucontrol=010 in EXECUTE; regwrite=regdst=1 in ALUWB; instret=1.
- lw (op=100011), memready=0 for 2 cycles in MEMRD -> state stays 3 for 3 cycles with iord=1 and regwrite=0. MEMWB then has memtoreg=1, regwrite=1. Total 7 cycles; instret +1.
- beq (op=000100), zero=1 then a second beq with zero=0 -> in BRANCH, alucontrol=110 and pcsrc=01; pcen=1 for the first, 0 for the second. instret +2.
- op=111111 (and separately op=000000, funct=000000) -> DECODE->ERROR, illegal=1, all enables 0 for 20 cycles. reset low clears to FETCH with illegal=0.
- sw with memready=0, reset driven low mid-MEMWR between clock edges -> memwrite falls to 0 without a clock edge, state=0. After release, a clean fetch occurs.
- CNT_WIDTH=4, 17 back-to-back j (op=000010) -> instret reads 1 after 17 retires (wraps at 16). Each j takes 3 cycles with pcsrc=10 in JUMP.
